sort_ctrl: RTL and testbench

- Control FSM for the in-place RAM sort datapath (counters i/j, registers A/B, comparator).
- Consumes the datapath status flags zi, zj and AgtB.
- Drives every datapath control strobe to run an exchange sort (ascending) over the 16-entry RAM.
- Reports completion and swap statistics to the host that loads the RAM (WrInit) and reads it back (Rd).

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_ctrl.sv | 133 +++++++++++++
 tb/tb_sort_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types for the in-place RAM exchange-sort controller.
package sort_pkg;

  localparam int K = 16;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    WR_I,
    WR_J,
    RELOAD_A,
    NEXT_J,
    NEXT_I,
    DONE
  } sort_state_t;

endpackage

// File: rtl/sort_ctrl.sv
// Control FSM for the RAM exchange sort: sequences counters i/j, registers A/B
// and RAM writes from the datapath flags, and keeps a saturating swap counter.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int SWAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              zi,
  input  logic              zj,
  input  logic              AgtB,
  output logic              Wr,
  output logic              Li,
  output logic              Ei,
  output logic              Lj,
  output logic              Ej,
  output logic              EA,
  output logic              EB,
  output logic              Csel,
  output logic              Bout,
  output logic              done,
  output logic              busy,
  output logic [SWAP_W-1:0] swap_cnt
);

  sort_state_t       state_q, state_d;
  logic [SWAP_W-1:0] swap_cnt_q, swap_cnt_d;
  logic              busy_s;

  function automatic logic [SWAP_W-1:0] sat_inc(input logic [SWAP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign busy_s   = (state_q != IDLE) && (state_q != DONE);
  assign swap_cnt = swap_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    swap_cnt_d = swap_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_A;
          swap_cnt_d = '0;
        end
      end
      LOAD_A:   state_d = LOAD_B;
      LOAD_B:   state_d = CMP;
      CMP:      state_d = AgtB ? WR_I : NEXT_J;
      WR_I:     state_d = WR_J;
      WR_J: begin
        state_d    = RELOAD_A;
        swap_cnt_d = sat_inc(swap_cnt_q);
      end
      RELOAD_A: state_d = NEXT_J;
      NEXT_J:   state_d = zj ? NEXT_I : LOAD_B;
      NEXT_I:   state_d = zi ? DONE : LOAD_A;
      DONE:     if (!start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Dropping start aborts any running sort; the statistic is left as-is.
    if (busy_s && !start) begin
      state_d    = IDLE;
      swap_cnt_d = swap_cnt_q;
    end
  end

  always_comb begin
    Wr   = 1'b0;
    Li   = 1'b0;
    Ei   = 1'b0;
    Lj   = 1'b0;
    Ej   = 1'b0;
    EA   = 1'b0;
    EB   = 1'b0;
    Csel = 1'b0;
    Bout = 1'b0;
    done = 1'b0;
    busy = busy_s;
    case (state_q)
      IDLE:     Li = 1'b1;
      LOAD_A: begin
        EA = 1'b1;
        Lj = 1'b1;
      end
      LOAD_B: begin
        Csel = 1'b1;
        EB   = 1'b1;
      end
      CMP: ;
      // Writes are suppressed on abort: the address mux already belongs to the host.
      WR_I: begin
        Bout = 1'b1;
        Wr   = start;
      end
      WR_J: begin
        Csel = 1'b1;
        Wr   = start;
      end
      RELOAD_A: EA = 1'b1;
      NEXT_J:   Ej = ~zj;
      NEXT_I:   Ei = ~zi;
      DONE:     done = 1'b1;
      default: ;
    endcase
    if (rst) begin
      Wr   = 1'b0;
      Li   = 1'b1;
      Ei   = 1'b0;
      Lj   = 1'b0;
      Ej   = 1'b0;
      EA   = 1'b0;
      EB   = 1'b0;
      Csel = 1'b0;
      Bout = 1'b0;
      done = 1'b0;
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Bench for sort_ctrl: two controllers (16-bit and 4-bit swap counters) each drive
// a behavioural RAM/counter/register datapath; results are compared to a sort model.
module tb_sort_ctrl;
  import sort_pkg::*;

  localparam int SW0 = 16;
  localparam int SW1 = 4;

  logic clk = 1'b0;
  logic rst, start, host_load;
  always #5 clk = ~clk;

  logic zi [2], zj [2], agtb [2];
  logic wr [2], li [2], ei [2], lj [2], ej [2], ea [2], eb [2], csel [2], bout [2];
  logic done [2], busy [2];
  logic [SW0-1:0] sc0;
  logic [SW1-1:0] sc1;

  logic [7:0] ram [2][16];
  logic [7:0] ra [2], rb [2];
  logic [3:0] ci [2], cj [2];
  logic [7:0] img [16];

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  sort_ctrl #(.SWAP_W(SW0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .zi(zi[0]), .zj(zj[0]), .AgtB(agtb[0]),
    .Wr(wr[0]), .Li(li[0]), .Ei(ei[0]), .Lj(lj[0]), .Ej(ej[0]), .EA(ea[0]), .EB(eb[0]),
    .Csel(csel[0]), .Bout(bout[0]), .done(done[0]), .busy(busy[0]), .swap_cnt(sc0)
  );

  sort_ctrl #(.SWAP_W(SW1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .zi(zi[1]), .zj(zj[1]), .AgtB(agtb[1]),
    .Wr(wr[1]), .Li(li[1]), .Ei(ei[1]), .Lj(lj[1]), .Ej(ej[1]), .EA(ea[1]), .EB(eb[1]),
    .Csel(csel[1]), .Bout(bout[1]), .done(done[1]), .busy(busy[1]), .swap_cnt(sc1)
  );

  function automatic logic [3:0] dp_addr(input logic c, input logic [3:0] i, input logic [3:0] j);
    return c ? j : i;
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      zi[k]   = (ci[k] == 4'(K - 2));
      zj[k]   = (cj[k] == 4'(K - 1));
      agtb[k] = (ra[k] > rb[k]);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (host_load) begin
        for (int a = 0; a < K; a++) ram[k][a] <= img[a];
      end else if (wr[k]) begin
        ram[k][dp_addr(csel[k], ci[k], cj[k])] <= bout[k] ? rb[k] : ra[k];
      end
      if (ea[k]) ra[k] <= ram[k][dp_addr(csel[k], ci[k], cj[k])];
      if (eb[k]) rb[k] <= ram[k][dp_addr(csel[k], ci[k], cj[k])];
      if (li[k]) ci[k] <= 4'd0;
      else if (ei[k]) ci[k] <= ci[k] + 4'd1;
      if (lj[k]) cj[k] <= ci[k] + 4'd1;
      else if (ej[k]) cj[k] <= cj[k] + 4'd1;
    end
  end

  // Structural rules that must hold in every cycle for both controllers.
  always @(negedge clk) begin
    if (!rst) begin
      if ((int'(wr[0]) + int'(ea[0]) + int'(eb[0]) > 1) ||
          (int'(wr[1]) + int'(ea[1]) + int'(eb[1]) > 1) ||
          ((li[0] | lj[0]) & (ei[0] | ej[0])) || ((li[1] | lj[1]) & (ei[1] | ej[1])) ||
          (ei[0] & zi[0]) || (ej[0] & zj[0]))
        viol <= viol + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain exchange sort over an array, counting exchanges.
  function automatic int exch_model(input logic [7:0] m_in [16], output logic [7:0] m_out [16]);
    logic [7:0] m [16];
    logic [7:0] t;
    int sw = 0;
    m = m_in;
    for (int i = 0; i < K - 1; i++)
      for (int j = i + 1; j < K; j++)
        if (m[i] > m[j]) begin
          t = m[i]; m[i] = m[j]; m[j] = t;
          sw++;
        end
    m_out = m;
    return sw;
  endfunction

  task automatic load_ram();
    host_load = 1'b1;
    @(negedge clk);
    host_load = 1'b0;
  endtask

  // Entered at a negedge with the controller in IDLE and start just raised (cycle 0).
  task automatic run_sort(input string name, input int exp_sw, input int exp_cyc,
                          input logic [7:0] exp_img [16]);
    int n = 0;
    int wrs = 0;
    int bad_busy = 0;
    int bad_ram = 0;
    chk({name, " busy_c0"}, 64'(busy[0]), 64'd0);
    while (!done[0] && n < 3000) begin
      @(negedge clk);
      n++;
      if (wr[0]) wrs++;
      if (!done[0] && !busy[0]) bad_busy++;
    end
    chk({name, " done_cycle"}, 64'(n), 64'(exp_cyc));
    chk({name, " writes"}, 64'(wrs), 64'(2 * exp_sw));
    chk({name, " busy_gap"}, 64'(bad_busy), 64'd0);
    chk({name, " swap_cnt16"}, 64'(sc0), 64'(exp_sw));
    chk({name, " swap_cnt4"}, 64'(sc1), 64'((exp_sw > 15) ? 15 : exp_sw));
    for (int a = 0; a < K; a++)
      for (int k = 0; k < 2; k++)
        if (ram[k][a] !== exp_img[a]) bad_ram++;
    chk({name, " ram_bad_words"}, 64'(bad_ram), 64'd0);
    repeat (3) @(negedge clk);
    chk({name, " done_held"}, {62'd0, done[0], busy[0]}, 64'd2);
    start = 1'b0;
    @(negedge clk);
    chk({name, " idle_after"}, {61'd0, done[0], busy[0], li[0]}, 64'd1);
  endtask

  typedef struct packed {
    logic [127:0] img;
    logic [127:0] exp;
    logic [15:0]  swaps;
    logic [15:0]  cycles;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [127:0] asc, dsc, sev, p3, p4;
    logic [7:0] m_exp [16];
    logic [7:0] tmp [16];
    int sw, k_abort, hits;

    for (int a = 0; a < K; a++) begin
      asc[8*a +: 8] = 8'(a);
      dsc[8*a +: 8] = 8'(15 - a);
      sev[8*a +: 8] = 8'd7;
    end
    p3 = asc; p3[7:0] = 8'd1; p3[15:8] = 8'd0;
    p4 = asc; p4[119:112] = 8'd15; p4[127:120] = 8'd14;
    tbl[0] = '{img: asc, exp: asc, swaps: 16'd0,   cycles: 16'd391};
    tbl[1] = '{img: dsc, exp: asc, swaps: 16'd120, cycles: 16'd751};
    tbl[2] = '{img: sev, exp: sev, swaps: 16'd0,   cycles: 16'd391};
    tbl[3] = '{img: p3,  exp: asc, swaps: 16'd1,   cycles: 16'd394};
    tbl[4] = '{img: p4,  exp: asc, swaps: 16'd1,   cycles: 16'd394};

    rst = 1'b1; start = 1'b0; host_load = 1'b0;
    #1;
    chk("in_reset_strobes", {53'd0, wr[0], li[0], ei[0], lj[0], ej[0], ea[0], eb[0],
                             csel[0], bout[0], done[0], busy[0]}, 64'h200);
    repeat (2) @(negedge clk);
    chk("reset_strobes", {53'd0, wr[0], li[0], ei[0], lj[0], ej[0], ea[0], eb[0],
                          csel[0], bout[0], done[0], busy[0]}, 64'h200);
    chk("reset_swap_cnt", {44'd0, sc1, sc0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int a = 0; a < K; a++) begin
        img[a]   = tbl[v].img[8*a +: 8];
        m_exp[a] = tbl[v].exp[8*a +: 8];
      end
      load_ram();
      start = 1'b1;
      run_sort($sformatf("vec%0d", v), int'(tbl[v].swaps), int'(tbl[v].cycles), m_exp);
    end

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < K; a++) img[a] = 8'($urandom_range(0, 255));
      sw = exch_model(img, m_exp);
      load_ram();
      start = 1'b1;
      run_sort($sformatf("rand%0d", r), sw, 391 + 3 * sw, m_exp);
    end

    // Abort in the k-th WR_J of a random sort, then sort whatever the RAM holds.
    do begin
      for (int a = 0; a < K; a++) img[a] = 8'($urandom_range(0, 255));
      sw = exch_model(img, m_exp);
    end while (sw < 3);
    k_abort = $urandom_range(1, 3);
    load_ram();
    start = 1'b1;
    hits = 0;
    for (int n = 0; n < 3000 && hits < k_abort; n++) begin
      @(negedge clk);
      if (wr[0] && csel[0]) hits++;
    end
    chk("abort_reached_wr_j", 64'(hits), 64'(k_abort));
    start = 1'b0;
    #1;
    chk("abort_wr_off", {62'd0, wr[0], wr[1]}, 64'd0);
    @(negedge clk);
    chk("abort_idle", {61'd0, busy[0], done[0], li[0]}, 64'd1);
    chk("abort_swap_cnt", 64'(sc0), 64'(k_abort - 1));
    repeat (3) @(negedge clk);
    chk("abort_swap_frozen", 64'(sc0), 64'(k_abort - 1));
    for (int a = 0; a < K; a++) tmp[a] = ram[0][a];
    sw = exch_model(tmp, m_exp);
    start = 1'b1;
    run_sort("restart", sw, 391 + 3 * sw, m_exp);

    // One-cycle reset in the middle of a descending sort, start held high.
    for (int a = 0; a < K; a++) img[a] = 8'(15 - a);
    load_ram();
    start = 1'b1;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_reset", {53'd0, wr[0], li[0], ei[0], lj[0], ej[0], ea[0], eb[0],
                            csel[0], bout[0], done[0], busy[0]}, 64'h200);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_after", {53'd0, wr[0], li[0], ei[0], lj[0], ej[0], ea[0], eb[0],
                         csel[0], bout[0], done[0], busy[0]}, 64'h200);
    chk("midrst_swap_cnt", {44'd0, sc1, sc0}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int a = 0; a < K; a++) tmp[a] = ram[0][a];
    sw = exch_model(tmp, m_exp);
    start = 1'b1;
    run_sort("after_rst", sw, 391 + 3 * sw, m_exp);

    chk("cycle_invariants", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
